dsm_decimator: RTL and testbench

Bitstream decoder for the first-order delta-sigma modulator: recovers a 9-bit signed value from the 1-bit DSM stream. It uses a second-order CIC (sinc²) decimator with a power-of-two ratio. It sits on the receive side of the DSM link, typically in the bench loopback and in the divider-control monitor path. It produces one decoded sample per R accepted input bits, with a valid strobe.

---
 rtl/dsm_pkg.sv | 6 +
 rtl/cic_comb2.sv | 48 ++++
 rtl/dsm_decimator.sv | 57 +++++
 tb/tb_dsm_decimator.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: levels and widths shared by the DSM modulator and decimator
package dsm_pkg;
    localparam int DATA_W    = 9;
    localparam int POS_LEVEL = 127;
    localparam int NEG_LEVEL = -128;
endpackage

// File: rtl/cic_comb2.sv
// cic_comb2: two-stage comb section and gated output register of the sinc^2 decimator
module cic_comb2
    import dsm_pkg::*;
#(
    parameter int W  = 21,
    parameter int SH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     take,
    input  logic signed [W-1:0]      acc,
    input  logic                     run,
    output logic signed [DATA_W-1:0] DO,
    output logic                     DO_valid,
    output logic                     done
);
    logic signed [W-1:0] snap, c1, d1, d2, c2, q;
    logic                tick, v1;

    assign c2   = c1 - d2;
    assign q    = c2 >>> SH;
    assign done = v1;

    // snapshot int2 at period end, then run the two comb stages on successive edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            tick     <= 1'b0;
            c1       <= '0;
            d1       <= '0;
            d2       <= '0;
            v1       <= 1'b0;
            DO       <= '0;
            DO_valid <= 1'b0;
        end else begin
            tick     <= take;
            v1       <= tick;
            DO_valid <= v1 && run;
            if (take) snap <= acc;
            if (tick) begin
                c1 <= snap - d1;
                d1 <= snap;
            end
            if (v1) d2 <= c1;
            if (v1 && run) DO <= q[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/dsm_decimator.sv
// dsm_decimator: sinc^2 decimator recovering a signed sample from a 1-bit DSM stream
module dsm_decimator
    import dsm_pkg::*;
#(
    parameter int R_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     DI,
    output logic signed [DATA_W-1:0] DO,
    output logic                     DO_valid
);
    localparam int W = DATA_W + 2 * R_LOG2;
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic signed [W-1:0] level, int1, int2, int1_n, int2_n;
    logic [R_LOG2-1:0]   cnt;
    logic [0:0]          state;
    logic                take, done;

    assign level  = DI ? W'(POS_LEVEL) : W'(NEG_LEVEL);
    assign int1_n = int1 + level;
    assign int2_n = int2 + int1_n;
    assign take   = en && (&cnt);

    // integrators and decimation counter advance only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1 <= '0;
            int2 <= '0;
            cnt  <= '0;
        end else if (en) begin
            int1 <= int1_n;
            int2 <= int2_n;
            cnt  <= cnt + 1'b1;
        end
    end

    // warm-up: the first comb output is discarded, everything after is published
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else if (done) state <= RUN;
    end

    cic_comb2 #(.W(W), .SH(2 * R_LOG2)) u_comb (
        .clk     (clk),
        .rst_n   (rst_n),
        .take    (take),
        .acc     (int2_n),
        .run     (state == RUN),
        .DO      (DO),
        .DO_valid(DO_valid),
        .done    (done)
    );
endmodule

// File: tb/tb_dsm_decimator.sv
// tb_dsm_decimator: directed checks of warm-up, decoding, stalls, loopback and reset
module tb_dsm_decimator;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic              DI = 1'b0;
    logic signed [8:0] DO;
    logic              DO_valid;

    int total = 0;
    int bad   = 0;
    int mode  = 3;
    logic dval = 1'b1;
    logic en_tog = 1'b0;
    int x = 0;
    int v_mod = 0;

    dsm_decimator #(.R_LOG2(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .DI      (DI),
        .DO      (DO),
        .DO_valid(DO_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // sample outputs on the falling edge, then drive inputs for the next rising edge
    task automatic cyc(output logic v);
        @(negedge clk);
        v = DO_valid;
        en = en_tog ? ~en : 1'b1;
        if (mode == 3) DI = 1'($urandom);
        else if (en) begin
            if (mode == 0) DI = dval;
            else if (mode == 1) DI = ~DI;
            else begin
                DI = (v_mod >= 0);
                v_mod = v_mod + x - (DI ? 127 : -128);
            end
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < maxc) begin
            cyc(v);
            n++;
        end
        if (!v) begin
            total++;
            bad++;
            $error("FAIL timeout got=%0d want=valid", n);
        end
    endtask

    task automatic skip(input int k);
        int n;
        for (int i = 0; i < k; i++) wait_valid(300, n);
    endtask

    initial begin
        logic v;
        int n;
        for (int i = 0; i < 10; i++) begin
            cyc(v);
            chk("rst_valid", int'(v), 0);
            chk("rst_do", int'(DO), 0);
        end
        rst_n = 1'b1;
        mode = 0;
        dval = 1'b1;
        DI = 1'b1;
        wait_valid(300, n);
        chk("first_latency", n, 130);
        chk("first_do_ones", int'(DO), 127);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("ones_spacing", n, 64);
            chk("ones_do", int'(DO), 127);
        end
        dval = 1'b0;
        skip(2);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("zeros_spacing", n, 64);
            chk("zeros_do", int'(DO), -128);
        end
        mode = 1;
        skip(2);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("alt_do", int'(DO), -1);
        end
        mode = 0;
        dval = 1'b1;
        en_tog = 1'b1;
        skip(2);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("stall_spacing", n, 128);
            chk("stall_do", int'(DO), 127);
        end
        en_tog = 1'b0;
        mode = 2;
        x = 50;
        v_mod = 0;
        skip(2);
        for (int i = 0; i < 3; i++) begin
            wait_valid(300, n);
            chk("loop_50", int'(DO >= 45 && DO <= 55), 1);
        end
        x = -100;
        skip(1);
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("loop_m100", int'(DO >= -105 && DO <= -95), 1);
        end
        mode = 0;
        dval = 1'b1;
        skip(3);
        chk("pre_reset_do", int'(DO), 127);
        for (int i = 0; i < 100; i++) cyc(v);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(v);
            chk("mid_rst_valid", int'(v), 0);
            chk("mid_rst_do", int'(DO), 0);
        end
        rst_n = 1'b1;
        wait_valid(300, n);
        chk("mid_rst_latency", n, 130);
        chk("mid_rst_do_after", int'(DO), 127);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
